// File: rtl/renode_pkg.sv
// Shared AHB types and the HBURST length decode used by the arbiter and AHB interface code.
package renode_pkg;

   localparam int unsigned BEAT_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [3:0] {
      SINGLE  = 4'b0000,
      INCR    = 4'b0001,
      WRAP4   = 4'b0010,
      INCR4   = 4'b0011,
      WRAP8   = 4'b0100,
      INCR8   = 4'b0101,
      WRAP16  = 4'b0110,
      INCR16  = 4'b0111,
      WRAP32  = 4'b1000,
      INCR32  = 4'b1001,
      WRAP64  = 4'b1010,
      INCR64  = 4'b1011,
      WRAP128 = 4'b1100,
      INCR128 = 4'b1101,
      WRAP256 = 4'b1110,
      INCR256 = 4'b1111
   } hburst_e;

   // Pairs of codes share a length of 2^(code[3:1]+1); SINGLE and undefined INCR count as one beat.
   function automatic int unsigned ahb_burst_len(hburst_e burst);
      logic [3:0] code;
      code = 4'(burst);
      if (code[3:1] == 3'd0) return 32'd1;
      return 32'd1 << (32'(code[3:1]) + 32'd1);
   endfunction

endpackage

// File: rtl/renode_ahb_if.sv
// Arbitration signals of one shared AHB segment; HLOCK/HMASTLOCK exist only with RENODE_AHB_ARB_HLOCK_EN.
interface renode_ahb_if #(
   parameter int unsigned NUM_MASTERS = 4
);
   import renode_pkg::*;

   localparam int unsigned MW = $clog2(NUM_MASTERS);

   logic [NUM_MASTERS-1:0] HBUSREQ;
   htrans_e                HTRANS;
   hburst_e                HBURST;
   logic                   HREADY;
   logic [NUM_MASTERS-1:0] HGRANT;
   logic [MW-1:0]          HMASTER;
   logic                   arb_busy;
`ifdef RENODE_AHB_ARB_HLOCK_EN
   logic [NUM_MASTERS-1:0] HLOCK;
   logic                   HMASTLOCK;
`endif

   modport master (
      output HBUSREQ, HTRANS, HBURST, HREADY,
`ifdef RENODE_AHB_ARB_HLOCK_EN
      output HLOCK,
      input  HMASTLOCK,
`endif
      input  HGRANT, HMASTER, arb_busy
   );

   modport slave (
      input  HBUSREQ, HTRANS, HBURST, HREADY,
`ifdef RENODE_AHB_ARB_HLOCK_EN
      input  HLOCK,
      output HMASTLOCK,
`endif
      output HGRANT, HMASTER, arb_busy
   );

endinterface

// File: rtl/renode_ahb_rr_picker.sv
// Combinational round-robin selector: first requester after last wins, last itself has lowest priority.
module renode_ahb_rr_picker #(
   parameter  int unsigned N  = 4,
   localparam int unsigned LW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [LW-1:0] last_i,
   input  logic [LW-1:0] park_i,
   output logic [LW-1:0] winner_c_o
);

   logic [LW-1:0] idx;
   logic          found;

   always_comb begin
      winner_c_o = park_i;
      found      = 1'b0;
      idx        = '0;
      for (int unsigned off = 1; off <= N; off++) begin
         idx = LW'((32'(last_i) + off) % N);
         if (!found && req_i[idx]) begin
            winner_c_o = idx;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/renode_ahb_arbiter.sv
// Burst-aware round-robin AHB arbiter producing HGRANT/HMASTER.
// Optional master locking is compiled in with RENODE_AHB_ARB_HLOCK_EN.
module renode_ahb_arbiter
   import renode_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = 4,
   parameter int unsigned PARK_MASTER = 0
) (
   input logic         HCLK,
   input logic         HRESETn,
   renode_ahb_if.slave bus
);

   localparam int unsigned            MW         = $clog2(NUM_MASTERS);
   localparam logic [MW-1:0]          PARK_IDX   = MW'(PARK_MASTER);
   localparam logic [NUM_MASTERS-1:0] PARK_GRANT = NUM_MASTERS'(1) << PARK_MASTER;

   logic [MW-1:0]          cur_q, cur_d, hmaster_q, winner_c;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [BEAT_W-1:0]      beats_q, beats_d;
   logic                   incr_open_q, incr_open_d;
   logic                   busy_q;
   logic                   arb_point, own_req;

   renode_ahb_rr_picker #(.N(NUM_MASTERS)) u_picker (
      .req_i      (bus.HBUSREQ),
      .last_i     (cur_q),
      .park_i     (PARK_IDX),
      .winner_c_o (winner_c)
   );

   // Burst tracking and arbitration-point detection; BUSY and stalled cycles never arbitrate.
   always_comb begin
      beats_d     = beats_q;
      incr_open_d = incr_open_q;
      arb_point   = 1'b0;
      own_req     = bus.HBUSREQ[cur_q];
      if (bus.HREADY && (bus.HTRANS != BUSY)) begin
         case (bus.HTRANS)
            IDLE: begin
               arb_point   = 1'b1;
               incr_open_d = 1'b0;
            end
            NONSEQ: begin
               beats_d     = BEAT_W'(ahb_burst_len(bus.HBURST) - 32'd1);
               incr_open_d = (bus.HBURST == INCR);
               arb_point   = (beats_d == '0) && !incr_open_d;
            end
            default: begin
               if (beats_q != '0) beats_d = beats_q - BEAT_W'(1);
               arb_point = (beats_d == '0) && !incr_open_q;
            end
         endcase
         // An open-ended INCR ends when its owner lets go of the request.
         if (incr_open_q && !own_req) begin
            arb_point   = 1'b1;
            incr_open_d = 1'b0;
         end
      end
`ifdef RENODE_AHB_ARB_HLOCK_EN
      if (bus.HLOCK[cur_q]) arb_point = 1'b0;
`endif
      cur_d          = arb_point ? winner_c : cur_q;
      grant_d        = '0;
      grant_d[cur_d] = 1'b1;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         cur_q       <= PARK_IDX;
         grant_q     <= PARK_GRANT;
         hmaster_q   <= PARK_IDX;
         beats_q     <= '0;
         incr_open_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         cur_q       <= cur_d;
         grant_q     <= grant_d;
         beats_q     <= beats_d;
         incr_open_q <= incr_open_d;
         busy_q      <= (beats_d != '0);
         if (bus.HREADY) hmaster_q <= cur_q;
      end
   end

`ifdef RENODE_AHB_ARB_HLOCK_EN
   logic hmastlock_q;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)        hmastlock_q <= 1'b0;
      else if (bus.HREADY) hmastlock_q <= bus.HLOCK[cur_q];
   end

   assign bus.HMASTLOCK = hmastlock_q;
`endif

   assign bus.HGRANT   = grant_q;
   assign bus.HMASTER  = hmaster_q;
   assign bus.arb_busy = busy_q;

endmodule

// File: tb/tb_renode_ahb_arbiter.sv
// Bench for renode_ahb_arbiter: directed scenarios plus random traffic against a rule-level model.
module tb_renode_ahb_arbiter;
   import renode_pkg::*;

   localparam int unsigned NM   = 4;
   localparam int unsigned PARK = 0;

   logic HCLK = 1'b0;
   logic HRESETn;
   int   n_checks = 0;
   int   n_pass   = 0;

   renode_ahb_if #(.NUM_MASTERS(NM)) bus ();

   renode_ahb_arbiter #(.NUM_MASTERS(NM), .PARK_MASTER(PARK)) dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .bus     (bus)
   );

   always #5 HCLK = ~HCLK;

   // Model state: owner, address-phase owner, beats still due, open-ended INCR flag.
   int blen [16] = '{1, 1, 4, 4, 8, 8, 16, 16, 32, 32, 64, 64, 128, 128, 256, 256};
   int m_cur, m_mst, m_left;
   bit m_open;
`ifdef RENODE_AHB_ARB_HLOCK_EN
   bit          m_mlock;
   logic [NM-1:0] lock_v;
`endif

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Priority list is cur+1, cur+2, ... ending with cur itself; nobody asking parks the bus.
   function automatic int rr_pick(logic [NM-1:0] req, int cur);
      for (int k = 1; k <= int'(NM); k++)
         if (req[(cur + k) % int'(NM)]) return (cur + k) % int'(NM);
      return int'(PARK);
   endfunction

   task automatic model_reset();
      m_cur  = int'(PARK);
      m_mst  = int'(PARK);
      m_left = 0;
      m_open = 1'b0;
`ifdef RENODE_AHB_ARB_HLOCK_EN
      m_mlock = 1'b0;
`endif
   endtask

   task automatic model_step(input logic [NM-1:0] req, input htrans_e tr, input hburst_e hb,
                             input logic rdy);
      bit arb;
      int left_n;
      bit open_n;
      arb    = 1'b0;
      left_n = m_left;
      open_n = m_open;
      if (rdy && tr != BUSY) begin
         if (tr == IDLE) begin
            arb    = 1'b1;
            open_n = 1'b0;
         end else if (tr == NONSEQ) begin
            left_n = blen[int'(hb)] - 1;
            open_n = (hb == INCR);
            arb    = (left_n == 0) && !open_n;
         end else begin
            left_n = (m_left > 0) ? m_left - 1 : 0;
            arb    = (left_n == 0) && !m_open;
         end
         if (m_open && !req[m_cur]) begin
            arb    = 1'b1;
            open_n = 1'b0;
         end
      end
`ifdef RENODE_AHB_ARB_HLOCK_EN
      if (lock_v[m_cur]) arb = 1'b0;
      if (rdy) m_mlock = lock_v[m_cur];
`endif
      if (rdy) m_mst = m_cur;
      if (arb) m_cur = rr_pick(req, m_cur);
      m_left = left_n;
      m_open = open_n;
   endtask

   task automatic compare_model();
      check_eq("grant",    32'(bus.HGRANT),   32'd1 << m_cur);
      check_eq("hmaster",  32'(bus.HMASTER),  32'(m_mst));
      check_eq("arb_busy", 32'(bus.arb_busy), 32'(m_left != 0));
`ifdef RENODE_AHB_ARB_HLOCK_EN
      check_eq("hmastlock", 32'(bus.HMASTLOCK), 32'(m_mlock));
`endif
   endtask

   // Called at a negedge: drive one address-phase cycle, then check at the following negedge.
   task automatic cycle(input logic [NM-1:0] req, input htrans_e tr, input hburst_e hb,
                        input logic rdy);
      bus.HBUSREQ = req;
      bus.HTRANS  = tr;
      bus.HBURST  = hb;
      bus.HREADY  = rdy;
`ifdef RENODE_AHB_ARB_HLOCK_EN
      bus.HLOCK = lock_v;
`endif
      model_step(req, tr, hb, rdy);
      @(negedge HCLK);
      compare_model();
   endtask

   initial begin
      logic [NM-1:0] r;
      htrans_e       t;
      hburst_e       b;
      logic          rd;
      int            acc;

      HRESETn     = 1'b0;
      bus.HBUSREQ = '0;
      bus.HTRANS  = IDLE;
      bus.HBURST  = SINGLE;
      bus.HREADY  = 1'b1;
`ifdef RENODE_AHB_ARB_HLOCK_EN
      lock_v    = '0;
      bus.HLOCK = '0;
`endif
      model_reset();
      repeat (3) @(negedge HCLK);
      check_eq("rst_grant",   32'(bus.HGRANT),   32'h1);
      check_eq("rst_hmaster", 32'(bus.HMASTER),  32'h0);
      check_eq("rst_busy",    32'(bus.arb_busy), 32'h0);
      HRESETn = 1'b1;

      // Idle park
      repeat (20) cycle('0, IDLE, SINGLE, 1'b1);
      check_eq("park_grant",   32'(bus.HGRANT),  32'h1);
      check_eq("park_hmaster", 32'(bus.HMASTER), 32'h0);

      // Masters 1 and 3 alternate on SINGLE transfers
      cycle(4'b1010, IDLE, SINGLE, 1'b1);
      check_eq("rr_1a", 32'(bus.HGRANT), 32'b0010);
      cycle(4'b1010, NONSEQ, SINGLE, 1'b1);
      check_eq("rr_3a", 32'(bus.HGRANT), 32'b1000);
      cycle(4'b1010, IDLE, SINGLE, 1'b1);
      check_eq("rr_1b", 32'(bus.HGRANT), 32'b0010);
      cycle(4'b1010, NONSEQ, SINGLE, 1'b1);
      check_eq("rr_3b", 32'(bus.HGRANT), 32'b1000);

      // Master 2 INCR8 with HREADY toggling while master 0 waits
      cycle(4'b0100, IDLE, SINGLE, 1'b1);
      cycle(4'b0100, IDLE, SINGLE, 1'b1);
      check_eq("own2_hmaster", 32'(bus.HMASTER), 32'd2);
      cycle(4'b0101, NONSEQ, INCR8, 1'b1);
      check_eq("incr8_busy", 32'(bus.arb_busy), 32'h1);
      acc = 0;
      rd  = 1'b0;
      while (acc < 7) begin
         cycle(4'b0101, SEQ, INCR8, rd);
         if (rd) acc++;
         if (acc < 7) check_eq("incr8_hold", 32'(bus.HGRANT), 32'b0100);
         rd = ~rd;
      end
      check_eq("incr8_handoff", 32'(bus.HGRANT), 32'b0001);

      // WRAP4 with BUSY at beat 3
      cycle(4'b0010, IDLE, SINGLE, 1'b1);
      cycle(4'b0011, NONSEQ, WRAP4, 1'b1);
      cycle(4'b0011, SEQ, WRAP4, 1'b1);
      cycle(4'b0011, BUSY, WRAP4, 1'b1);
      cycle(4'b0011, BUSY, WRAP4, 1'b1);
      check_eq("wrap4_busy_grant", 32'(bus.HGRANT),   32'b0010);
      check_eq("wrap4_busy_flag",  32'(bus.arb_busy), 32'h1);
      cycle(4'b0011, SEQ, WRAP4, 1'b1);
      cycle(4'b0011, SEQ, WRAP4, 1'b1);
      check_eq("wrap4_end", 32'(bus.HGRANT), 32'b0001);

      // Undefined INCR by master 1, released after 5 beats
      cycle(4'b0010, IDLE, SINGLE, 1'b1);
      cycle(4'b0110, NONSEQ, INCR, 1'b1);
      repeat (4) cycle(4'b0110, SEQ, INCR, 1'b1);
      check_eq("incr_hold", 32'(bus.HGRANT), 32'b0010);
      cycle(4'b0100, SEQ, INCR, 1'b1);
      check_eq("incr_release", 32'(bus.HGRANT), 32'b0100);

      // Asynchronous reset at beat 4 of INCR16 owned by master 1
      cycle(4'b0010, IDLE, SINGLE, 1'b1);
      cycle(4'b0010, IDLE, SINGLE, 1'b1);
      cycle(4'b0011, NONSEQ, INCR16, 1'b1);
      cycle(4'b0011, SEQ, INCR16, 1'b1);
      cycle(4'b0011, SEQ, INCR16, 1'b1);
      check_eq("pre_rst_busy", 32'(bus.arb_busy), 32'h1);
      bus.HTRANS = SEQ;
      #2 HRESETn = 1'b0;
      #1;
      check_eq("async_rst_grant",   32'(bus.HGRANT),   32'h1);
      check_eq("async_rst_hmaster", 32'(bus.HMASTER),  32'h0);
      check_eq("async_rst_busy",    32'(bus.arb_busy), 32'h0);
      @(negedge HCLK);
      HRESETn = 1'b1;
      model_reset();
      cycle(4'b0010, IDLE, SINGLE, 1'b1);
      check_eq("post_rst_grant", 32'(bus.HGRANT), 32'b0010);

`ifdef RENODE_AHB_ARB_HLOCK_EN
      // Locked master 0 keeps the bus over two INCR4 bursts
      cycle(4'b0001, IDLE, SINGLE, 1'b1);
      lock_v = 4'b0001;
      for (int k = 0; k < 2; k++) begin
         cycle(4'b0011, NONSEQ, INCR4, 1'b1);
         repeat (3) cycle(4'b0011, SEQ, INCR4, 1'b1);
         check_eq("lock_hold", 32'(bus.HGRANT), 32'b0001);
      end
      check_eq("lock_flag", 32'(bus.HMASTLOCK), 32'h1);
      lock_v = '0;
      cycle(4'b0011, IDLE, SINGLE, 1'b1);
      check_eq("lock_release", 32'(bus.HGRANT), 32'b0010);
`endif

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         r  = NM'($urandom);
         t  = htrans_e'($urandom_range(0, 3));
         b  = hburst_e'($urandom_range(0, 15));
         rd = ($urandom_range(0, 3) != 0);
`ifdef RENODE_AHB_ARB_HLOCK_EN
         lock_v = ($urandom_range(0, 7) == 0) ? NM'($urandom) : '0;
`endif
         cycle(r, t, b, rd);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/renode_ahb_arbiter.md
# renode_ahb_arbiter

Round-robin, burst-aware bus arbiter that shares one `renode_ahb_if` AHB segment between up to `NUM_MASTERS` requesters. It sits between the Renode-driven and RTL masters and the address/control mux. It generates one-hot `HGRANT` and the address-phase owner index `HMASTER`. It never re-arbitrates inside a fixed-length burst.

## Interface
- `NUM_MASTERS`, 4: number of requesters, 2..16.
- `PARK_MASTER`, 0: index granted when no request is pending and after reset.
- `MW`, `$clog2(NUM_MASTERS)`: width of `HMASTER` (localparam).
- `HCLK` in, 1: bus clock, single clock domain.
- `HRESETn` in, 1: reset, asynchronous assert, active-low.
- `HBUSREQ` in, `NUM_MASTERS`: per-master bus request, level.
- `HTRANS` in, 2: muxed bus transfer type of the current address-phase owner.
- `HBURST` in, 4: muxed burst type, sampled on `NONSEQ`.
- `HREADY` in, 1: muxed bus ready; an address phase is accepted when `HREADY` is 1.
- `HGRANT` out, `NUM_MASTERS`: one-hot grant, registered.
- `HMASTER` out, `MW`: index driving the address phase, registered; selects the address/control mux.
- `arb_busy` out, 1: 1 while a fixed-length burst is in progress (`beats_left` != 0).

## Operation
- State `cur`, the granted index, is the one-hot position in `HGRANT`.
- Burst counter `beats_left`, 8 bits:
  - On accepted `NONSEQ`, it loads burst length − 1. Lengths follow the team's `HBURST` decode: SINGLE/INCR→1, WRAP4/INCR4→4, … WRAP256/INCR256→256.
  - On accepted `SEQ`, it decrements, saturating at 0.
  - `BUSY` and `IDLE` leave it unchanged.
- Undefined INCR (`HBURST` = 4'b0001) sets flag `incr_open`. `incr_open` clears on accepted `IDLE`, on the next `NONSEQ`, or when `HBUSREQ[cur]` is 0.
- An arbitration point is a cycle with `HREADY` = 1 and any of the following:
  - `HTRANS` = IDLE.
  - Accepted `NONSEQ`/`SEQ` leaving `beats_left` = 0 with `incr_open` = 0, i.e. the final beat or SINGLE.
  - `incr_open` = 1 and `HBUSREQ[cur]` = 0.
- At an arbitration point the next grant is selected as follows:
  - Search starts at `(cur+1) mod NUM_MASTERS`, wraps around, and the first set `HBUSREQ` bit wins.
  - `cur` itself is the lowest priority, so it keeps the bus only if it is the sole requester.
  - With no request pending, the grant goes to `PARK_MASTER`.
- `HBURST` values and counter arithmetic are unsigned; a length of 256 loads 255 and never overflows the 8-bit counter.
- `HTRANS` = `BUSY` is never an arbitration point.

## Timing
- Reset values: `HGRANT` = one-hot `PARK_MASTER`, `HMASTER` = `PARK_MASTER`, `beats_left` = 0, `incr_open` = 0, `arb_busy` = 0. Recovery from reset is synchronous to `HCLK`.
- Grant update:
  - `HGRANT` takes the new value on the `HCLK` edge that ends the arbitration-point cycle, giving 1-cycle grant latency.
  - If the winner equals `cur`, `HGRANT` is unchanged.
- `HMASTER` copies the `HGRANT` index on the first edge where `HREADY` = 1 after `HGRANT` changes. With `HREADY` held 0, `HMASTER` holds its old value for any number of cycles.
- Simultaneous events:
  - A final beat accepted in the same cycle that a new `NONSEQ` is presented by the same owner is impossible by protocol.
  - If `HBUSREQ` drops on a non-arbitration cycle, it is ignored until the next arbitration point.
  - A requester that asserts and drops `HBUSREQ` between arbitration points is never granted.
- Reset mid-burst: all state returns to reset values immediately; the burst is abandoned.

## Configuration
- `RENODE_AHB_ARB_HLOCK_EN` defined:
  - Adds input `HLOCK`, width `NUM_MASTERS`, and output `HMASTLOCK`, width 1.
  - While `HLOCK[cur]` = 1, arbitration points are suppressed and `cur` keeps the grant.
  - `HMASTLOCK` is registered `HLOCK[cur]`, updated alongside `HMASTER` (on `HREADY` = 1 edges), reset 0.
- Not defined: no lock ports. Arbitration follows the Operation section only.

## Structure
- Shared package `renode_pkg` holds:
  - typedef `htrans_e` (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11);
  - typedef `hburst_e`;
  - function `ahb_burst_len(hburst_e)` returning `int unsigned`, to be shared with the AHB interface code.
- Sub-module `renode_ahb_rr_picker`: combinational round-robin selector, parameter `N`.
  - Inputs: `req[N]`, `last[$clog2(N)]`, `park`.
  - Output: winner index.
- The top module keeps the burst counter, flags, and grant/`HMASTER` registers.

## Test plan
- Reset release with `HBUSREQ` = 0 → `HGRANT` = 4'b0001, `HMASTER` = 0, and both hold for 20 cycles.
- Masters 1 and 3 request together, each issuing SINGLE+IDLE → grants go 1, 3, 1, 3 in order; each `HGRANT` change lands 1 cycle after the IDLE address phase.
- Master 2 issues INCR8 with `HREADY` toggling 0/1 while master 0 requests → `HGRANT` stays 4'b0100 for all 8 accepted beats; master 0 is granted only after the 8th.
- `BUSY` inserted at beat 3 of WRAP4 → `beats_left` freezes at 2 and `HGRANT` is unchanged.
- Master 1 runs undefined INCR, then drops `HBUSREQ` after 5 beats while master 2 requests → grant moves to 2 on the next `HREADY` = 1 edge.
- `HRESETn` pulsed low at beat 4 of INCR16 → outputs return to reset values asynchronously, then idle arbitration resumes. With `RENODE_AHB_ARB_HLOCK_EN`, a locked master 0 retains the grant across two back-to-back INCR4 bursts despite master 1 requesting.
